slurm32_pipeline_ctrl: RTL and testbench

SLURM32_PIPELINE_CTRL -- requirements
Module: slurm32_pipeline_ctrl

---
 rtl/slurm32_pipeline_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_slurm32_pipeline_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slurm32_pipeline_ctrl.sv
// Pipeline sequencing controller for the SLURM32 core: issues PC loads, pipeline
// flushes, sleep/debug stalls and interrupt entry. Every output is registered.
module slurm32_pipeline_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] VECTOR_BASE  = 32'h00000100,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        branch_req,
    input  logic [31:0] branch_addr,
    input  logic        sleep_req,
    input  logic        interrupt,
    input  logic [3:0]  irq,
    input  logic        int_enable,
    input  logic [31:0] resume_pc,
    input  logic        debugger_halt_request,
    input  logic        debugger_load_pc_request,
    input  logic [31:0] debugger_load_pc_address,
    output logic        pc_load,
    output logic [31:0] pc_load_address,
    output logic        flush,
    output logic        stall,
    output logic        irq_ack,
    output logic [3:0]  irq_ack_num,
    output logic [31:0] int_return_addr,
    output logic        halted,
    output logic        dbg_halted
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_RUN,
        ST_FLUSH,
        ST_SLEEP,
        ST_DBG_HALT
    } state_t;

    // Counter preload: flush stays high on the load cycle plus CNT_LOAD more.
    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pending_flush_q, pending_flush_d;
    logic        from_flush_q, from_flush_d;

    logic        pc_load_q, pc_load_d;
    logic [31:0] pc_load_address_q, pc_load_address_d;
    logic        flush_q, flush_d;
    logic        stall_q, stall_d;
    logic        irq_ack_q, irq_ack_d;
    logic [3:0]  irq_ack_num_q, irq_ack_num_d;
    logic [31:0] int_return_addr_q, int_return_addr_d;
    logic        halted_q, halted_d;
    logic        dbg_halted_q, dbg_halted_d;

    logic        irq_take;
    logic [31:0] irq_vector;

    assign irq_take   = interrupt & int_enable;
    assign irq_vector = VECTOR_BASE + {24'h000000, irq, 4'h0};

    // NOTE: the whole register set, including address latches, clears on reset
    // so that nothing downstream sees stale vectors after a restart.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q           <= ST_RESET;
            cnt_q             <= '0;
            pending_flush_q   <= 1'b0;
            from_flush_q      <= 1'b0;
            pc_load_q         <= 1'b0;
            pc_load_address_q <= '0;
            flush_q           <= 1'b0;
            stall_q           <= 1'b0;
            irq_ack_q         <= 1'b0;
            irq_ack_num_q     <= '0;
            int_return_addr_q <= '0;
            halted_q          <= 1'b0;
            dbg_halted_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            pending_flush_q   <= pending_flush_d;
            from_flush_q      <= from_flush_d;
            pc_load_q         <= pc_load_d;
            pc_load_address_q <= pc_load_address_d;
            flush_q           <= flush_d;
            stall_q           <= stall_d;
            irq_ack_q         <= irq_ack_d;
            irq_ack_num_q     <= irq_ack_num_d;
            int_return_addr_q <= int_return_addr_d;
            halted_q          <= halted_d;
            dbg_halted_q      <= dbg_halted_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pending_flush_d = pending_flush_q;
        from_flush_d    = from_flush_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_LOAD;
            end
            ST_RUN: begin
                if (debugger_halt_request) begin
                    state_d      = ST_DBG_HALT;
                    from_flush_d = 1'b0;
                end else if (branch_req || irq_take) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                end else if (sleep_req) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_FLUSH: begin
                if (debugger_halt_request) begin
                    state_d      = ST_DBG_HALT;
                    from_flush_d = 1'b1;
                    cnt_d        = '0;
                end else if (cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_SLEEP: begin
                if (debugger_halt_request) begin
                    state_d      = ST_DBG_HALT;
                    from_flush_d = 1'b0;
                end else if (irq_take) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_LOAD;
                end else if (interrupt) begin
                    state_d = ST_RUN;
                end
            end
            ST_DBG_HALT: begin
                if (debugger_load_pc_request) begin
                    pending_flush_d = 1'b1;
                end
                if (!debugger_halt_request) begin
                    pending_flush_d = 1'b0;
                    from_flush_d    = 1'b0;
                    if (pending_flush_q || from_flush_q || debugger_load_pc_request) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Output logic looks one step ahead so every output lands in a flop.
    always_comb begin
        pc_load_d         = 1'b0;
        irq_ack_d         = 1'b0;
        pc_load_address_d = pc_load_address_q;
        irq_ack_num_d     = irq_ack_num_q;
        int_return_addr_d = int_return_addr_q;
        flush_d           = (state_d == ST_FLUSH);
        stall_d           = (state_d == ST_SLEEP) || (state_d == ST_DBG_HALT);
        halted_d          = (state_d == ST_SLEEP);
        dbg_halted_d      = (state_d == ST_DBG_HALT);
        case (state_q)
            ST_RESET: begin
                pc_load_d         = 1'b1;
                pc_load_address_d = RESET_VECTOR;
            end
            ST_RUN, ST_SLEEP: begin
                if (!debugger_halt_request) begin
                    if (state_q == ST_RUN && branch_req) begin
                        pc_load_d         = 1'b1;
                        pc_load_address_d = branch_addr;
                    end else if (irq_take) begin
                        pc_load_d         = 1'b1;
                        pc_load_address_d = irq_vector;
                        irq_ack_d         = 1'b1;
                        irq_ack_num_d     = irq;
                        int_return_addr_d = resume_pc;
                    end
                end
            end
            ST_DBG_HALT: begin
                if (debugger_load_pc_request) begin
                    pc_load_d         = 1'b1;
                    pc_load_address_d = debugger_load_pc_address;
                end
            end
            default: ;
        endcase
    end

    assign pc_load         = pc_load_q;
    assign pc_load_address = pc_load_address_q;
    assign flush           = flush_q;
    assign stall           = stall_q;
    assign irq_ack         = irq_ack_q;
    assign irq_ack_num     = irq_ack_num_q;
    assign int_return_addr = int_return_addr_q;
    assign halted          = halted_q;
    assign dbg_halted      = dbg_halted_q;

endmodule

// File: tb/tb_slurm32_pipeline_ctrl.sv
// Scoreboard bench for slurm32_pipeline_ctrl: stimulus queues expected PC loads
// and flush burst lengths, a negedge monitor pops and compares them.
module tb_slurm32_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        branch_req;
    logic [31:0] branch_addr;
    logic        sleep_req;
    logic        interrupt;
    logic [3:0]  irq;
    logic        int_enable;
    logic [31:0] resume_pc;
    logic        debugger_halt_request;
    logic        debugger_load_pc_request;
    logic [31:0] debugger_load_pc_address;
    logic        pc_load;
    logic [31:0] pc_load_address;
    logic        flush;
    logic        stall;
    logic        irq_ack;
    logic [3:0]  irq_ack_num;
    logic [31:0] int_return_addr;
    logic        halted;
    logic        dbg_halted;

    typedef struct {
        logic [31:0] addr;
        logic        is_irq;
        logic [3:0]  num;
        logic [31:0] ret;
    } load_t;

    load_t load_q[$];
    int    flush_len_q[$];
    int    total = 0;
    int    bad   = 0;

    slurm32_pipeline_ctrl dut (
        .CLK                      (CLK),
        .RSTb                     (RSTb),
        .branch_req               (branch_req),
        .branch_addr              (branch_addr),
        .sleep_req                (sleep_req),
        .interrupt                (interrupt),
        .irq                      (irq),
        .int_enable               (int_enable),
        .resume_pc                (resume_pc),
        .debugger_halt_request    (debugger_halt_request),
        .debugger_load_pc_request (debugger_load_pc_request),
        .debugger_load_pc_address (debugger_load_pc_address),
        .pc_load                  (pc_load),
        .pc_load_address          (pc_load_address),
        .flush                    (flush),
        .stall                    (stall),
        .irq_ack                  (irq_ack),
        .irq_ack_num              (irq_ack_num),
        .int_return_addr          (int_return_addr),
        .halted                   (halted),
        .dbg_halted               (dbg_halted)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_load(input logic [31:0] addr, input logic is_irq,
                             input logic [3:0] num, input logic [31:0] ret);
        load_t e;
        e.addr = addr;
        e.is_irq = is_irq;
        e.num = num;
        e.ret = ret;
        load_q.push_back(e);
    endtask

    task automatic check_run(input string name);
        check({name, "_run"}, {29'd0, flush, stall, dbg_halted}, 32'd0);
    endtask

    // Monitor: compares every pc_load against the queue and every flush burst length.
    initial begin
        int    run_len;
        load_t e;
        run_len = 0;
        forever begin
            @(negedge CLK);
            if (pc_load) begin
                if (load_q.size() == 0) begin
                    fail("unexpected_pc_load");
                end else begin
                    e = load_q.pop_front();
                    check("pc_load_address", pc_load_address, e.addr);
                    check("irq_ack", {31'd0, irq_ack}, {31'd0, e.is_irq});
                    if (e.is_irq) begin
                        check("irq_ack_num", {28'd0, irq_ack_num}, {28'd0, e.num});
                        check("int_return_addr", int_return_addr, e.ret);
                    end
                end
            end else if (irq_ack) begin
                fail("irq_ack_without_pc_load");
            end
            if (flush) begin
                run_len++;
            end else if (run_len > 0) begin
                if (flush_len_q.size() == 0) fail("unexpected_flush");
                else check("flush_len", run_len, flush_len_q.pop_front());
                run_len = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTb = 1'b0;
        branch_req = 1'b0;
        branch_addr = '0;
        sleep_req = 1'b0;
        interrupt = 1'b0;
        irq = '0;
        int_enable = 1'b0;
        resume_pc = '0;
        debugger_halt_request = 1'b0;
        debugger_load_pc_request = 1'b0;
        debugger_load_pc_address = '0;

        // Reset state
        tick();
        tick();
        check("reset_ctrl", {26'd0, pc_load, flush, stall, irq_ack, halted, dbg_halted}, 32'd0);
        check("reset_ret", int_return_addr, 32'd0);

        // Reset release: load reset vector, flush 3 cycles
        push_load(32'h00000000, 1'b0, 4'd0, 32'd0);
        flush_len_q.push_back(3);
        RSTb = 1'b1;
        tick();
        check("release_flush", {31'd0, flush}, 32'd1);
        repeat (3) tick();
        check_run("release");

        // Branch; a second branch during flush is ignored
        push_load(32'h00001000, 1'b0, 4'd0, 32'd0);
        flush_len_q.push_back(3);
        branch_req = 1'b1;
        branch_addr = 32'h00001000;
        tick();
        branch_addr = 32'h00003000;
        tick();
        branch_req = 1'b0;
        repeat (2) tick();
        check_run("branch");

        // Branch and interrupt together: branch first, interrupt after flush
        push_load(32'h00000800, 1'b0, 4'd0, 32'd0);
        flush_len_q.push_back(3);
        push_load(32'h00000150, 1'b1, 4'd5, 32'h00000040);
        flush_len_q.push_back(3);
        branch_req = 1'b1;
        branch_addr = 32'h00000800;
        interrupt = 1'b1;
        irq = 4'd5;
        int_enable = 1'b1;
        resume_pc = 32'h00000040;
        tick();
        branch_req = 1'b0;
        repeat (4) tick();
        check("irq_taken_after_flush", {31'd0, irq_ack}, 32'd1);
        interrupt = 1'b0;
        repeat (3) tick();
        check_run("irq5");

        // Highest IRQ number boundary
        push_load(32'h000001F0, 1'b1, 4'd15, 32'hFFFFFFFC);
        flush_len_q.push_back(3);
        interrupt = 1'b1;
        irq = 4'd15;
        resume_pc = 32'hFFFFFFFC;
        tick();
        interrupt = 1'b0;
        repeat (3) tick();
        check_run("irq15");

        // Sleep, woken by a masked interrupt: back to RUN without a load
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        check("sleep_enter", {30'd0, halted, stall}, 32'd3);
        tick();
        check("sleep_hold", {30'd0, halted, stall}, 32'd3);
        interrupt = 1'b1;
        int_enable = 1'b0;
        irq = 4'd3;
        tick();
        interrupt = 1'b0;
        check("wake_masked", {29'd0, halted, stall, pc_load}, 32'd0);
        check_run("wake_masked");

        // Sleep, woken by an enabled interrupt: vector load
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        check("sleep_enter2", {31'd0, halted}, 32'd1);
        push_load(32'h00000120, 1'b1, 4'd2, 32'h00000088);
        flush_len_q.push_back(3);
        interrupt = 1'b1;
        int_enable = 1'b1;
        irq = 4'd2;
        resume_pc = 32'h00000088;
        tick();
        interrupt = 1'b0;
        check("wake_irq", {30'd0, halted, stall}, 32'd0);
        repeat (3) tick();
        check_run("wake_irq");

        // Debugger halt mid-flush, debugger PC load, release reflushes
        push_load(32'h00001000, 1'b0, 4'd0, 32'd0);
        flush_len_q.push_back(2);
        branch_req = 1'b1;
        branch_addr = 32'h00001000;
        tick();
        branch_req = 1'b0;
        tick();
        debugger_halt_request = 1'b1;
        tick();
        check("dbg_enter", {29'd0, dbg_halted, stall, flush}, 32'd6);
        push_load(32'h00002000, 1'b0, 4'd0, 32'd0);
        debugger_load_pc_request = 1'b1;
        debugger_load_pc_address = 32'h00002000;
        tick();
        debugger_load_pc_request = 1'b0;
        tick();
        check("dbg_hold", {31'd0, dbg_halted}, 32'd1);
        flush_len_q.push_back(3);
        debugger_halt_request = 1'b0;
        tick();
        check("dbg_release", {30'd0, dbg_halted, flush}, 32'd1);
        repeat (3) tick();
        check_run("dbg_release");

        // Debugger halt beats a same-cycle branch; plain release goes to RUN
        debugger_halt_request = 1'b1;
        branch_req = 1'b1;
        branch_addr = 32'h00005555;
        tick();
        branch_req = 1'b0;
        check("dbg_priority", {30'd0, dbg_halted, pc_load}, 32'd2);
        debugger_halt_request = 1'b0;
        tick();
        check_run("dbg_plain_release");

        // Reset during sleep clears everything; release repeats the boot sequence
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        check("sleep_before_reset", {31'd0, halted}, 32'd1);
        RSTb = 1'b0;
        tick();
        check("reset_sleep_ctrl", {26'd0, pc_load, flush, stall, irq_ack, halted, dbg_halted}, 32'd0);
        check("reset_sleep_addr", pc_load_address, 32'd0);
        check("reset_sleep_ret", int_return_addr, 32'd0);
        check("reset_sleep_num", {28'd0, irq_ack_num}, 32'd0);
        push_load(32'h00000000, 1'b0, 4'd0, 32'd0);
        flush_len_q.push_back(3);
        RSTb = 1'b1;
        tick();
        repeat (3) tick();
        check_run("reboot");

        repeat (2) tick();
        check("loads_outstanding", load_q.size(), 32'd0);
        check("flushes_outstanding", flush_len_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
